// File: rtl/gate2_checker.sv
// Self-test sequencer for a 2-input gate: applies vectors 00..11 in order, holds each
// for HOLD cycles, samples y and compares it against the EXPECT truth table.
module gate2_checker #(
    parameter int         HOLD   = 2,
    parameter logic [3:0] EXPECT = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] err_vec
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0] HOLD_L = 4'(HOLD);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] idx;
    logic [3:0] hold_cnt;
    logic       sample;

    // The counter is loaded with HOLD, so the edge that takes it from 1 to 0 is the
    // HOLD-th edge after the vector was applied.
    assign sample = (state == RUN) && (hold_cnt == 4'd1);

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update from the same pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first in every always_comb, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (sample && idx == 2'd3) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= 2'd0;
            hold_cnt  <= 4'd0;
            err_count <= 3'd0;
            err_vec   <= 4'd0;
            a         <= 1'b0;
            b         <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        idx       <= 2'd0;
                        hold_cnt  <= HOLD_L;
                        err_count <= 3'd0;
                        err_vec   <= 4'd0;
                        {a, b}    <= 2'b00;
                    end
                end
                RUN: begin
                    if (sample) begin
                        if (y != EXPECT[idx]) begin
                            err_count    <= (err_count == 3'd4) ? err_count : err_count + 3'd1;
                            err_vec[idx] <= 1'b1;
                        end
                        if (idx == 2'd3) begin
                            hold_cnt <= 4'd0;
                            {a, b}   <= 2'b11;
                        end else begin
                            idx      <= idx + 2'd1;
                            hold_cnt <= HOLD_L;
                            {a, b}   <= idx + 2'd1;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
        pass = done && (err_count == 3'd0);
    end

endmodule

// File: tb/tb_gate2_checker.sv
// Scoreboard bench for gate2_checker: HOLD=2 instance against several gate models,
// plus a HOLD=1 instance against a correct AND.
module tb_gate2_checker;

    typedef struct {
        logic [2:0] ec;
        logic [3:0] ev;
        logic       pass;
    } exp_t;

    localparam logic [3:0] TRUTH = 4'b1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start_v = 2'b00;
    logic [1:0] y_v;
    logic [1:0] a_o, b_o, busy_o, done_o, pass_o;
    logic [1:0][2:0] ec_o;
    logic [1:0][3:0] ev_o;

    int   mode = 0;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    gate2_checker #(.HOLD(2), .EXPECT(TRUTH)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .y(y_v[0]),
        .a(a_o[0]), .b(b_o[0]), .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]),
        .err_count(ec_o[0]), .err_vec(ev_o[0])
    );

    gate2_checker #(.HOLD(1), .EXPECT(TRUTH)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .y(y_v[1]),
        .a(a_o[1]), .b(b_o[1]), .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]),
        .err_count(ec_o[1]), .err_vec(ev_o[1])
    );

    // 0: AND, 1: stuck at 0, 2: OR, 3: NAND
    function automatic logic gate(input int m, input logic ga, input logic gb);
        case (m)
            0:       return ga & gb;
            1:       return 1'b0;
            2:       return ga | gb;
            default: return ~(ga & gb);
        endcase
    endfunction

    always_comb begin
        y_v[0] = gate(mode, a_o[0], b_o[0]);
        y_v[1] = gate(0, a_o[1], b_o[1]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_all_zero(input string tag, input int w);
        check({tag, "_ab"}, {a_o[w], b_o[w]}, 0);
        check({tag, "_busy"}, busy_o[w], 0);
        check({tag, "_done"}, done_o[w], 0);
        check({tag, "_pass"}, pass_o[w], 0);
        check({tag, "_ec"}, ec_o[w], 0);
        check({tag, "_ev"}, ev_o[w], 0);
    endtask

    // Runs one check sequence on instance w; restart_at re-pulses start at that edge,
    // abort_at asserts rst between that edge and the next.
    task automatic do_run(input int w, input int m, input int restart_at, input int abort_at);
        int   hold;
        int   edges;
        bit   fin;
        exp_t e;
        hold = (w == 0) ? 2 : 1;
        e.ev = '0;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] v;
            v = 2'(i);
            e.ev[i] = (gate(m, v[1], v[0]) != TRUTH[i]);
        end
        e.ec   = 3'($countones(e.ev));
        e.pass = (e.ec == 3'd0);
        sb.push_back(e);
        mode = m;

        start_v[w] = 1'b1;
        @(posedge clk);
        #1 start_v[w] = 1'b0;
        check("start_busy", busy_o[w], 1);
        check("start_done", done_o[w], 0);
        check("start_ec", ec_o[w], 0);
        check("start_ev", ev_o[w], 0);
        check("start_ab", {a_o[w], b_o[w]}, 0);

        edges = 0;
        fin   = 1'b0;
        while (!fin && edges < 40) begin
            if (restart_at > 0 && edges == restart_at - 1) start_v[w] = 1'b1;
            @(posedge clk);
            #1;
            edges++;
            start_v[w] = 1'b0;
            if (abort_at > 0 && edges == abort_at) begin
                #3 rst = 1'b1;
                #1 check_all_zero("abort", w);
                repeat (2) @(posedge clk);
                #1 check_all_zero("abort_hold", w);
                @(negedge clk) rst = 1'b0;
                void'(sb.pop_back());
                return;
            end
            if (done_o[w]) fin = 1'b1;
            else check("ab_step", {a_o[w], b_o[w]}, edges / hold);
        end
        check("timeout", fin, 1);
        check("latency", edges, 4 * hold);

        e = sb.pop_front();
        check("err_count", ec_o[w], e.ec);
        check("err_vec", ev_o[w], e.ev);
        check("pass", pass_o[w], e.pass);
        check("done_busy", busy_o[w], 0);
        check("done_ab", {a_o[w], b_o[w]}, 3);
        repeat (3) @(posedge clk);
        #1;
        check("hold_done", done_o[w], 1);
        check("hold_ec", ec_o[w], e.ec);
        check("hold_ev", ev_o[w], e.ev);
        check("hold_pass", pass_o[w], e.pass);
    endtask

    initial begin
        #1 check_all_zero("reset0", 0);
        check_all_zero("reset1", 1);
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset_clk", 0);
        @(negedge clk) rst = 1'b0;

        do_run(0, 0, 0, 0);   // start on first edge after reset, correct AND
        do_run(0, 1, 0, 0);   // stuck at 0
        do_run(0, 2, 0, 0);   // OR
        do_run(0, 3, 0, 0);   // NAND, saturates at 4
        do_run(0, 0, 0, 3);   // reset between edges 3 and 4
        do_run(0, 0, 0, 0);   // full run after abort
        do_run(0, 2, 2, 0);   // start re-pulsed mid-run
        do_run(0, 0, 0, 0);   // start from DONE clears and reruns
        do_run(1, 0, 0, 0);   // HOLD=1

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
